// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
//   Definitions shared between the memory-side responder and the control unit.
//   - Strobe bit positions inside the control word. The order is
//     MEM_W, MEM_RST, MEM_R, MEM_OE, MEM_CE, starting at bit 0.
//   - Responder FSM state type.
//   - Default fill value for the clear sweep.
package mem_bus_pkg;

  // Strobe bit positions in the control word
  localparam int MEM_W   = 0;
  localparam int MEM_RST = 1;
  localparam int MEM_R   = 2;
  localparam int MEM_OE  = 3;
  localparam int MEM_CE  = 4;
  localparam int CTRL_W  = 5;

  // Responder states
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } resp_state_t;

  // Byte written to every location by the clear sweep
  localparam logic [7:0] CLR_VAL_DEFAULT = 8'h00;

endpackage : mem_bus_pkg

// File: rtl/mem_bus_responder_spram.sv
// spram_sync
//   Single-port synchronous byte RAM (DEPTH x DW). Infers block RAM.
//   The read data register updates only on a read access (en & ~we), so it
//   holds the last value read. The array has no reset.
// Ports:
//   clk    in   clock
//   en     in   access enable
//   we     in   write enable (qualified by en)
//   addr   in   AW-bit word address
//   wdata  in   write data
//   rdata  out  registered read data
module spram_sync #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_array [DEPTH];
  logic [DW-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_array[addr] <= wdata;
      end else begin
        rdata_reg <= mem_array[addr];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule : spram_sync

// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Memory-side responder for the CPU strobe bus. Services two-cycle reads
//   (address phase with mem_r, then output phase with mem_oe), single-cycle
//   writes, and a DEPTH-cycle clear sweep triggered by mem_rst.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   mem_ce     in   chip enable; all other strobes ignored when low
//   mem_r      in   read address phase
//   mem_oe     in   output enable
//   mem_w      in   write strobe
//   mem_rst    in   start (or restart) the clear sweep
//   addr_in    in   16-bit address; only the low AW bits index the array
//   data_in    in   write data
//   data_out   out  read data, 8'h00 when data_oe is low
//   data_oe    out  data_out valid (bus tristate enable)
//   busy       out  clear sweep in progress
//   proto_err  out  sticky protocol-violation flag
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int         DEPTH   = 256,
  parameter int         AW      = 8,
  parameter logic [7:0] CLR_VAL = CLR_VAL_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ce,
  input  logic        mem_r,
  input  logic        mem_oe,
  input  logic        mem_w,
  input  logic        mem_rst,
  input  logic [15:0] addr_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        busy,
  output logic        proto_err
);

  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

  resp_state_t   state_reg,     state_next;
  logic [AW-1:0] clr_cnt_reg,   clr_cnt_next;
  logic          proto_err_reg, proto_err_next;
  // The RAM read register cannot be reset, so the architectural read
  // register is modelled as "forced to zero" until the next accepted read.
  logic          rd_zero_reg,   rd_zero_next;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  logic [7:0]    rd_val;

  spram_sync #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (8)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Upper address bits alias onto the array.
  generate
    if (AW < 16) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_in[15:AW];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      clr_cnt_reg   <= '0;
      proto_err_reg <= 1'b0;
      rd_zero_reg   <= 1'b1;
    end else begin
      state_reg     <= state_next;
      clr_cnt_reg   <= clr_cnt_next;
      proto_err_reg <= proto_err_next;
      rd_zero_reg   <= rd_zero_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clr_cnt_next   = clr_cnt_reg;
    proto_err_next = proto_err_reg;
    rd_zero_next   = rd_zero_reg;
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = addr_in[AW-1:0];
    ram_wdata      = data_in;

    case (state_reg)
      IDLE: begin
        if (mem_ce) begin
          if (mem_rst) begin
            // Sweep entry drops any concurrent access.
            state_next   = CLEAR;
            clr_cnt_next = '0;
            rd_zero_next = 1'b1;
            if (mem_r || mem_w) proto_err_next = 1'b1;
          end else if (mem_w) begin
            // Write wins over a simultaneous read.
            ram_en = 1'b1;
            ram_we = 1'b1;
            if (mem_r) proto_err_next = 1'b1;
          end else if (mem_r) begin
            ram_en       = 1'b1;
            rd_zero_next = 1'b0;
          end
        end
      end

      CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_cnt_reg;
        ram_wdata = CLR_VAL;
        if (mem_ce && (mem_r || mem_w)) proto_err_next = 1'b1;
        if (mem_ce && mem_rst) begin
          clr_cnt_next = '0;
          rd_zero_next = 1'b1;
        end else if (clr_cnt_reg == CLR_LAST) begin
          state_next   = IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg == CLEAR);
  assign proto_err = proto_err_reg;
  assign rd_val    = rd_zero_reg ? 8'h00 : ram_rdata;
  assign data_oe   = mem_ce & mem_oe & ~busy;
  assign data_out  = data_oe ? rd_val : 8'h00;

endmodule : mem_bus_responder

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder (DEPTH=256).
module tb_mem_bus_responder;

  logic        clk;
  logic        rst_n;
  logic        mem_ce, mem_r, mem_oe, mem_w, mem_rst;
  logic [15:0] addr_in;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe, busy, proto_err;

  int checks = 0;
  int errors = 0;

  mem_bus_responder #(
    .DEPTH   (256),
    .AW      (8),
    .CLR_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_ce    (mem_ce),
    .mem_r     (mem_r),
    .mem_oe    (mem_oe),
    .mem_w     (mem_w),
    .mem_rst   (mem_rst),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .busy      (busy),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic idle_in();
    mem_ce = 0; mem_r = 0; mem_oe = 0; mem_w = 0; mem_rst = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [15:0] a, input logic [7:0] d);
    idle_in();
    mem_ce = 1; mem_w = 1; addr_in = a; data_in = d;
    step();
    idle_in();
  endtask

  // Address phase, then oe phase; checks the byte during oe.
  task automatic read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
    idle_in();
    mem_ce = 1; mem_r = 1; addr_in = a;
    step();
    mem_r = 0; mem_oe = 1;
    #1;
    check({tag, "_oe"}, {15'd0, data_oe}, 16'd1);
    check(tag, {8'd0, data_out}, {8'd0, exp});
    step();
    idle_in();
  endtask

  int cnt;

  initial begin
    idle_in();
    addr_in = 16'h0; data_in = 8'h0;
    rst_n = 0;
    repeat (3) step();
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_perr", {15'd0, proto_err}, 16'd0);
    check("rst_oe", {15'd0, data_oe}, 16'd0);
    check("rst_dout", {8'd0, data_out}, 16'd0);
    rst_n = 1;
    step();

    // oe without prior read drives the reset value of rd_reg
    mem_ce = 1; mem_oe = 1; #1;
    check("noread_oe", {15'd0, data_oe}, 16'd1);
    check("noread_dout", {8'd0, data_out}, 16'h0000);
    step(); idle_in();

    // Basic write/read
    write_byte(16'h0010, 8'hA5);
    read_check("rd_0010", 16'h0010, 8'hA5);
    #1;
    check("oe_drop_dout", {8'd0, data_out}, 16'h0000);
    check("oe_drop_oe", {15'd0, data_oe}, 16'd0);

    // Aliasing of upper address bits
    write_byte(16'h1234, 8'h3C);
    read_check("alias_0034", 16'h0034, 8'h3C);

    // Overlapped reads with oe held high
    write_byte(16'h0040, 8'h11);
    write_byte(16'h0041, 8'h22);
    mem_ce = 1; mem_oe = 1; mem_r = 1; addr_in = 16'h0040; #1;
    check("ovl_old", {8'd0, data_out}, 16'h003C);
    step();
    addr_in = 16'h0041; #1;
    check("ovl_first", {8'd0, data_out}, 16'h0011);
    step();
    mem_r = 0; #1;
    check("ovl_second", {8'd0, data_out}, 16'h0022);
    step(); idle_in();
    check("ovl_perr", {15'd0, proto_err}, 16'd0);

    // Read/write conflict
    mem_ce = 1; mem_r = 1; mem_w = 1; addr_in = 16'h0020; data_in = 8'h77;
    step(); idle_in();
    check("conf_perr", {15'd0, proto_err}, 16'd1);
    mem_ce = 1; mem_oe = 1; #1;
    check("conf_rdreg", {8'd0, data_out}, 16'h0022);
    step(); idle_in();
    read_check("conf_loc", 16'h0020, 8'h77);
    check("conf_sticky", {15'd0, proto_err}, 16'd1);

    // rst_n clears proto_err and rd_reg, not the array
    rst_n = 0; #2; rst_n = 1;
    step();
    check("rst2_perr", {15'd0, proto_err}, 16'd0);
    mem_ce = 1; mem_oe = 1; #1;
    check("rst2_rdreg", {8'd0, data_out}, 16'h0000);
    step(); idle_in();
    read_check("rst2_keep", 16'h0020, 8'h77);

    // Clear sweep
    write_byte(16'h0000, 8'hFF);
    write_byte(16'h007F, 8'hFF);
    write_byte(16'h00FF, 8'hFF);
    write_byte(16'h0005, 8'hFF);
    mem_ce = 1; mem_rst = 1;
    step(); idle_in();
    cnt = 0;
    while (busy && cnt < 1000) begin
      idle_in();
      if (cnt == 10) begin
        mem_ce = 1; mem_w = 1; addr_in = 16'h0005; data_in = 8'hAB;
      end else if (cnt == 20) begin
        mem_ce = 1; mem_oe = 1; #1;
        check("clr_oe_blocked", {15'd0, data_oe}, 16'd0);
      end
      cnt++;
      step();
    end
    idle_in();
    check("clr_busy_cycles", cnt[15:0], 16'd256);
    check("clr_perr", {15'd0, proto_err}, 16'd1);
    mem_ce = 1; mem_oe = 1; #1;
    check("clr_rdreg", {8'd0, data_out}, 16'h0000);
    step(); idle_in();
    read_check("clr_0", 16'h0000, 8'h00);
    read_check("clr_127", 16'h007F, 8'h00);
    read_check("clr_255", 16'h00FF, 8'h00);
    read_check("clr_5_ignored", 16'h0005, 8'h00);

    // Async reset mid-sweep
    write_byte(16'h000A, 8'hFF);
    write_byte(16'h00C8, 8'hFF);
    mem_ce = 1; mem_rst = 1;
    step(); idle_in();
    check("abort_busy_start", {15'd0, busy}, 16'd1);
    repeat (40) step();
    #2;
    rst_n = 0;
    #1;
    check("abort_busy_async", {15'd0, busy}, 16'd0);
    check("abort_perr", {15'd0, proto_err}, 16'd0);
    @(negedge clk);
    rst_n = 1;
    step();
    read_check("abort_10", 16'h000A, 8'h00);
    read_check("abort_200", 16'h00C8, 8'hFF);
    check("abort_idle", {15'd0, busy}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_bus_responder
